seg7_scan_driver: RTL and testbench

Time-multiplexed 4-digit seven-segment display driver, directly downstream of the timer's digit counters (units/tens for seconds and minutes). Latches the four 4-bit digit values once per frame and scans them onto a common-anode display. Drives segments with a 7-segment decode, leading-zero blanking, per-digit decimal points and an anti-ghosting blank interval.

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_scan_driver.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the seven-segment scan driver:
//   - active-low segment patterns, ordered {g,f,e,d,c,b,a}
//   - per-slot scan state encoding (BLANK / DRIVE)
//   - slot counter width and the shadow register layout
//   - leading-zero blanking helper
package seg7_pkg;

  localparam int SLOT_W = 2;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_A    = 7'h08;
  localparam logic [6:0] SEG_B    = 7'h03;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_D    = 7'h21;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_F    = 7'h0E;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Frame-stable copy of everything the display shows.
  typedef struct packed {
    logic [3:0][3:0] digit;      // digit[i] is shown on an[i]
    logic [3:0]      dp_mask;
    logic            blank_lead;
  } shadow_t;

  // Bit i set means digit i is a suppressed leading zero. Blanking
  // ripples down from the most significant digit; digit0 always shows.
  function automatic logic [3:0] lead_blank_mask(input logic [3:0][3:0] digits,
                                                 input logic            enable);
    logic [3:0] mask;
    mask[3] = enable & (digits[3] == 4'd0);
    mask[2] = mask[3] & (digits[2] == 4'd0);
    mask[1] = mask[2] & (digits[1] == 4'd0);
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Purely combinational 4-bit value to active-low segment pattern.
//   Ports:
//     value  in  4  value to display
//     hex_en in  1  1: 10..15 show as A,b,C,d,E,F; 0: they show a dash
//     seg    out 7  {g,f,e,d,c,b,a}, active low
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_en,
  output logic [6:0] seg
);

  // Segment lookup; values above 9 fall back to a dash when hex is off.
  always_comb begin
    seg = SEG_OFF;
    case (value)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = hex_en ? SEG_A : SEG_DASH;
      4'd11: seg = hex_en ? SEG_B : SEG_DASH;
      4'd12: seg = hex_en ? SEG_C : SEG_DASH;
      4'd13: seg = hex_en ? SEG_D : SEG_DASH;
      4'd14: seg = hex_en ? SEG_E : SEG_DASH;
      4'd15: seg = hex_en ? SEG_F : SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed 4-digit common-anode seven-segment driver. Digit
//   values are captured into shadow registers once per frame so a frame
//   never mixes old and new data; each digit slot starts with an
//   all-off interval to suppress ghosting.
//   Parameters:
//     REFRESH_DIV  clk cycles per digit slot (>= BLANK_CYCLES+2)
//     BLANK_CYCLES all-off cycles at the start of each slot (0 allowed)
//     HEX_EN       1: show 10..15 as hex letters, 0: show a dash
//   Ports:
//     clk, reset          clock; asynchronous active-high reset
//     digit0..digit3      digit values, digit0 is rightmost (an[0])
//     dp_mask             bit i lights decimal point of digit i
//     blank_lead          enable leading-zero blanking
//     an, seg, dp         active-low anode, segment, decimal point pins
//     frame_start         one-cycle pulse when the shadow registers load
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit HEX_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_mask,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int                PCNT_W    = $clog2(REFRESH_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [PCNT_W-1:0] BLANK_LIM = PCNT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(3);

  logic [PCNT_W-1:0] pcnt_r;
  logic [SLOT_W-1:0] slot_r;
  scan_state_e       state_r;
  logic              loaded_r;   // clears on reset so the first cycle loads
  shadow_t           shadow_r;

  logic [PCNT_W-1:0] pcnt_nxt_s;
  logic [SLOT_W-1:0] slot_nxt_s;
  logic              wrap_s;
  logic              load_s;
  logic [3:0]        blanked_s;
  logic [3:0]        digit_sel_s;
  logic [6:0]        seg_dec_s;
  logic              drive_s;

  // Next prescaler/slot values, shadow load strobe and per-slot visibility.
  always_comb begin
    wrap_s = (pcnt_r == PCNT_LAST);
    if (wrap_s) begin
      pcnt_nxt_s = '0;
      slot_nxt_s = slot_r + SLOT_W'(1);
    end else begin
      pcnt_nxt_s = pcnt_r + PCNT_W'(1);
      slot_nxt_s = slot_r;
    end
    load_s      = ~loaded_r | (wrap_s & (slot_r == SLOT_LAST));
    digit_sel_s = shadow_r.digit[slot_r];
    blanked_s   = lead_blank_mask(shadow_r.digit, shadow_r.blank_lead);
    drive_s     = (state_r == DRIVE) & ~blanked_s[slot_r];
  end

  seg7_decode u_decode (
    .value  (digit_sel_s),
    .hex_en (HEX_EN),
    .seg    (seg_dec_s)
  );

  // Prescaler and digit slot counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_r <= '0;
      slot_r <= '0;
    end else begin
      pcnt_r <= pcnt_nxt_s;
      slot_r <= slot_nxt_s;
    end
  end

  // Blank/drive FSM with registered pin outputs. The state tracks the
  // upcoming prescaler value so it always describes the current pcnt;
  // the pins therefore follow pcnt/slot/state by exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= BLANK;
      an          <= 4'hF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      case (state_r)
        BLANK: begin
          if (pcnt_nxt_s >= BLANK_LIM) begin
            state_r <= DRIVE;
          end else begin
            state_r <= BLANK;
          end
        end
        DRIVE: begin
          if (pcnt_nxt_s < BLANK_LIM) begin
            state_r <= BLANK;
          end else begin
            state_r <= DRIVE;
          end
        end
        default: state_r <= BLANK;
      endcase

      if (drive_s) begin
        an  <= ~(4'b0001 << slot_r);
        seg <= seg_dec_s;
        dp  <= ~shadow_r.dp_mask[slot_r];
      end else begin
        an  <= 4'hF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
      frame_start <= load_s;
    end
  end

  // Shadow capture: first cycle after reset, then on every 3->0 slot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded_r <= 1'b0;
      shadow_r <= '0;
    end else if (load_s) begin
      loaded_r            <= 1'b1;
      shadow_r.digit      <= {digit3, digit2, digit1, digit0};
      shadow_r.dp_mask    <= dp_mask;
      shadow_r.blank_lead <= blank_lead;
    end else begin
      loaded_r <= loaded_r;
      shadow_r <= shadow_r;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1.
// Two instances share the inputs: one with hex letters, one with dashes.
module tb_seg7_scan_driver;

  localparam int DIV = 4;
  localparam int BLK = 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
  logic [3:0] dp_mask = 4'd0;
  logic       blank_lead = 1'b0;

  logic [3:0] an,   an_n;
  logic [6:0] seg,  seg_n;
  logic       dp,   dp_n;
  logic       fs,   fs_n;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .HEX_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .dp_mask(dp_mask), .blank_lead(blank_lead),
    .an(an), .seg(seg), .dp(dp), .frame_start(fs)
  );

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .HEX_EN(1'b0)) u_dash (
    .clk(clk), .reset(reset),
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .dp_mask(dp_mask), .blank_lead(blank_lead),
    .an(an_n), .seg(seg_n), .dp(dp_n), .frame_start(fs_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference decode tables.
  logic [6:0] dec_hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] dec_dash [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Reference model state: k = index of the clock edge since reset release.
  int              k;
  logic [3:0][3:0] sh_dig;
  logic [3:0]      sh_dpm;
  logic            sh_bl;

  typedef struct {
    logic [3:0][3:0] dig;     // dig[i] = digit i
    logic [3:0]      dpm;
    logic            bl;
    logic [3:0]      lit;     // bit i: anode i is driven during its slot
    logic [3:0][6:0] seg_h;   // [i] = seg in slot i, hex instance
    logic [3:0][6:0] seg_d;   // [i] = seg in slot i, dash instance
    logic [3:0]      dp_e;    // bit i: dp pin during slot i
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (k=%0d t=%0t): got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Digit i is a suppressed leading zero if blanking is on and it and
  // every digit to its left are zero; the rightmost digit always shows.
  function automatic logic lz(input logic [3:0][3:0] dg, input logic bl, input int i);
    if (!bl || i == 0) return 1'b0;
    for (int j = i; j < 4; j++) begin
      if (dg[j] != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance one clock edge, checking both instances against the model.
  task automatic step();
    int         p, s;
    logic [3:0] e_an;
    logic [6:0] e_seg, e_sgd;
    logic       e_dp, e_fs;
    p = k % DIV;
    s = (k / DIV) % 4;
    if (p < BLK || lz(sh_dig, sh_bl, s)) begin
      e_an = 4'hF; e_seg = 7'h7F; e_sgd = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = 4'hF;
      e_an[s] = 1'b0;
      e_seg = dec_hex[sh_dig[s]];
      e_sgd = dec_dash[sh_dig[s]];
      e_dp  = ~sh_dpm[s];
    end
    e_fs = (k == 0) || (k % (4 * DIV) == 4 * DIV - 1);
    if (e_fs) begin
      sh_dig = {d3, d2, d1, d0};
      sh_dpm = dp_mask;
      sh_bl  = blank_lead;
    end
    @(posedge clk);
    #1;
    check("scan", {an, seg, dp, fs}, {e_an, e_seg, e_dp, e_fs});
    check("dash", {an_n, seg_n, dp_n, fs_n}, {e_an, e_sgd, e_dp, e_fs});
    k++;
  endtask

  // Assert reset away from the clock edge, check immediate reset values,
  // release on the falling edge so the next rising edge is edge 0.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_vals", {an, seg, dp, fs, an_n, seg_n, dp_n, fs_n},
          {4'hF, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    reset  = 1'b0;
    k      = 0;
    sh_dig = '0;
    sh_dpm = 4'd0;
    sh_bl  = 1'b0;
  endtask

  task automatic set_in(input logic [3:0][3:0] dg, input logic [3:0] dpm, input logic bl);
    {d3, d2, d1, d0} = dg;
    dp_mask    = dpm;
    blank_lead = bl;
  endtask

  initial begin
    logic [3:0] exp_an;
    int         s;

    vt[0] = '{{4'd1,4'd2,4'd3,4'd4}, 4'b0000, 1'b0, 4'b1111,
              {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}, 4'b1111};
    vt[1] = '{{4'd0,4'd0,4'd5,4'd0}, 4'b0000, 1'b1, 4'b0011,
              {7'h7F,7'h7F,7'h12,7'h40}, {7'h7F,7'h7F,7'h12,7'h40}, 4'b1111};
    vt[2] = '{{4'd0,4'd0,4'd0,4'd0}, 4'b0000, 1'b1, 4'b0001,
              {7'h7F,7'h7F,7'h7F,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'b1111};
    vt[3] = '{{4'd0,4'd0,4'hB,4'd0}, 4'b0000, 1'b0, 4'b1111,
              {7'h40,7'h40,7'h03,7'h40}, {7'h40,7'h40,7'h3F,7'h40}, 4'b1111};
    vt[4] = '{{4'd1,4'd2,4'd3,4'd4}, 4'b0010, 1'b0, 4'b1111,
              {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}, 4'b1101};
    vt[5] = '{{4'd0,4'd0,4'd0,4'd7}, 4'b0010, 1'b1, 4'b0001,
              {7'h7F,7'h7F,7'h7F,7'h78}, {7'h7F,7'h7F,7'h7F,7'h78}, 4'b1111};
    vt[6] = '{{4'hF,4'hE,4'hD,4'hC}, 4'b1111, 1'b1, 4'b1111,
              {7'h0E,7'h06,7'h21,7'h46}, {7'h3F,7'h3F,7'h3F,7'h3F}, 4'b0000};
    vt[7] = '{{4'd0,4'd8,4'd0,4'd9}, 4'b0000, 1'b1, 4'b0111,
              {7'h7F,7'h00,7'h40,7'h10}, {7'h7F,7'h00,7'h40,7'h10}, 4'b1111};
    vt[8] = '{{4'd0,4'hA,4'd0,4'd6}, 4'b0100, 1'b1, 4'b0111,
              {7'h7F,7'h08,7'h40,7'h02}, {7'h7F,7'h3F,7'h40,7'h02}, 4'b1011};

    k = 0;
    #2;

    // Table-driven frames: one full frame per vector from reset.
    for (int v = 0; v < 9; v++) begin
      set_in(vt[v].dig, vt[v].dpm, vt[v].bl);
      do_reset();
      for (int c = 0; c < 4 * DIV; c++) begin
        step();
        s = c / DIV;
        if (c % DIV == 0) begin
          check("vec_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        end else if (c % DIV == 2) begin
          exp_an = 4'hF;
          if (vt[v].lit[s]) exp_an[s] = 1'b0;
          check("vec_an",   {28'd0, an},    {28'd0, exp_an});
          check("vec_seg",  {25'd0, seg},   {25'd0, vt[v].seg_h[s]});
          check("vec_segd", {25'd0, seg_n}, {25'd0, vt[v].seg_d[s]});
          check("vec_dp",   {31'd0, dp},    {31'd0, vt[v].dp_e[s]});
        end else begin
          n_tests = n_tests;
        end
      end
    end

    // Reset mid-slot, then restart timing.
    set_in(vt[0].dig, 4'b0000, 1'b0);
    do_reset();
    for (int c = 0; c < 6; c++) step();
    do_reset();
    step();
    check("restart_fs", {31'd0, fs}, 32'd1);
    check("restart_blank", {28'd0, an}, {28'd0, 4'hF});
    step();
    check("restart_drive", {an, seg}, {4'b1110, 7'h19});

    // Tearing: digit0 changes right after a load; old value holds all frame.
    set_in(vt[0].dig, 4'b0000, 1'b0);
    do_reset();
    for (int c = 0; c < 16; c++) step();
    d0 = 4'd7;
    for (int c = 16; c < 19; c++) step();
    check("tear_old", {an, seg}, {4'b1110, 7'h19});
    for (int c = 19; c < 32; c++) step();
    check("tear_fs", {31'd0, fs}, 32'd1);
    step();
    step();
    check("tear_new", {an, seg}, {4'b1110, 7'h78});
    // Change in slot 2 shows only after the next load.
    for (int c = 34; c < 41; c++) step();
    d0 = 4'd4;
    for (int c = 41; c < 50; c++) step();
    check("tear_slot2", {an, seg}, {4'b1110, 7'h19});

    // Random stimulus against the model, with occasional mid-run resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) begin
        d0 = 4'($urandom);
        d1 = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
        d2 = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
        d3 = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
        dp_mask    = 4'($urandom);
        blank_lead = 1'($urandom);
      end
      if ($urandom_range(149) == 0) begin
        do_reset();
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
